// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for the RISC-V datapath.
// Drives the stall, bubble and flush controls of the pipeline registers.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   rs1_if_id, rs2_if_id            sources of the instruction in ID
//   rs1_id_ex, rs2_id_ex, rd_id_ex  sources/dest of the instruction in EX
//   mem_read_id_ex                  EX instruction is a load
//   rd_ex_mem, rd_mem_wb            dest regs in MEM / WB
//   reg_write_ex_mem/_mem_wb        write enables in MEM / WB
//   mc_start                        multi-cycle op enters EX this cycle
//   branch_taken                    taken branch/jump resolved in EX
//   forward_rs1/2                   00 none, 01 from EX/MEM, 10 from MEM/WB
//   stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id
//   mc_busy                         multi-cycle unit occupied
//   stall_cycles                    saturating count of stall_pc cycles
//
// state   | meaning
// RUN     | normal flow; branch, multi-cycle start and load-use handled here
// MC_WAIT | multi-cycle op holds EX; front end stalled
// FLUSH   | squashing wrong-path instructions after a taken branch
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4,
  parameter int FLUSH_CYC  = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_if_id,
  input  logic [REG_ADDR_W-1:0] rs2_if_id,
  input  logic [REG_ADDR_W-1:0] rs1_id_ex,
  input  logic [REG_ADDR_W-1:0] rs2_id_ex,
  input  logic [REG_ADDR_W-1:0] rd_id_ex,
  input  logic                  mem_read_id_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex_mem,
  input  logic [REG_ADDR_W-1:0] rd_mem_wb,
  input  logic                  reg_write_ex_mem,
  input  logic                  reg_write_mem_wb,
  input  logic                  mc_start,
  input  logic                  branch_taken,
  output logic [1:0]            forward_rs1,
  output logic [1:0]            forward_rs2,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  stall_id_ex,
  output logic                  bubble_id_ex,
  output logic                  flush_if_id,
  output logic                  mc_busy,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int MAX_CYC = (MC_LAT > FLUSH_CYC) ? MC_LAT : FLUSH_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0]    MC_LOAD = CW'(MC_LAT - 1);
  localparam logic [CW-1:0]    FL_LOAD = CW'(FLUSH_CYC - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CNT_W-1:0] SC_MAX  = '1;

  typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load_use;

  // EX/MEM is checked first so the youngest producer wins.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_mem,
    input logic                  we_mem,
    input logic [REG_ADDR_W-1:0] rd_wb,
    input logic                  we_wb
  );
    if (we_mem && rs == rd_mem && rs != '0)
      return 2'b01;
    else if (we_wb && rs == rd_wb && rs != '0)
      return 2'b10;
    return 2'b00;
  endfunction

  assign forward_rs1 = fwd_sel(rs1_id_ex, rd_ex_mem, reg_write_ex_mem, rd_mem_wb, reg_write_mem_wb);
  assign forward_rs2 = fwd_sel(rs2_id_ex, rd_ex_mem, reg_write_ex_mem, rd_mem_wb, reg_write_mem_wb);

  assign load_use = mem_read_id_ex && rd_id_ex != '0 &&
                    (rd_id_ex == rs1_if_id || rd_id_ex == rs2_if_id);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    mc_busy      = 1'b0;
    case (state)
      RUN: begin
        // A taken branch squashes the instructions behind it, so any
        // mc_start or load-use seen in the same cycle is wrong-path.
        if (branch_taken) begin
          flush_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = FL_LOAD;
          end
        end else if (mc_start) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
          mc_busy     = 1'b1;
          if (MC_LAT > 1) begin
            state_nxt = MC_WAIT;
            cnt_nxt   = MC_LOAD;
          end
        end else if (load_use) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end
      end
      MC_WAIT: begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        stall_id_ex = 1'b1;
        mc_busy     = 1'b1;
        cnt_nxt     = cnt - CNT_ONE;
        if (cnt == CNT_ONE)
          state_nxt = RUN;
      end
      FLUSH: begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        cnt_nxt      = cnt - CNT_ONE;
        if (cnt == CNT_ONE)
          state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall_pc && stall_cycles != SC_MAX)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] rs1_if_id, rs2_if_id, rs1_id_ex, rs2_id_ex, rd_id_ex, rd_ex_mem, rd_mem_wb;
  logic mem_read_id_ex, reg_write_ex_mem, reg_write_mem_wb, mc_start, branch_taken;

  logic [1:0]  f1_a, f2_a, f1_b, f2_b;
  logic        sp_a, sif_a, sid_a, bub_a, fl_a, busy_a;
  logic        sp_b, sif_b, sid_b, bub_b, fl_b, busy_b;
  logic [15:0] sc_a;
  logic [3:0]  sc_b;

  hazard_ctrl u_a (
    .clk(clk), .rst_n(rst_n),
    .rs1_if_id(rs1_if_id), .rs2_if_id(rs2_if_id),
    .rs1_id_ex(rs1_id_ex), .rs2_id_ex(rs2_id_ex), .rd_id_ex(rd_id_ex),
    .mem_read_id_ex(mem_read_id_ex),
    .rd_ex_mem(rd_ex_mem), .rd_mem_wb(rd_mem_wb),
    .reg_write_ex_mem(reg_write_ex_mem), .reg_write_mem_wb(reg_write_mem_wb),
    .mc_start(mc_start), .branch_taken(branch_taken),
    .forward_rs1(f1_a), .forward_rs2(f2_a),
    .stall_pc(sp_a), .stall_if_id(sif_a), .stall_id_ex(sid_a),
    .bubble_id_ex(bub_a), .flush_if_id(fl_a), .mc_busy(busy_a),
    .stall_cycles(sc_a)
  );

  hazard_ctrl #(.MC_LAT(1), .FLUSH_CYC(1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .rs1_if_id(rs1_if_id), .rs2_if_id(rs2_if_id),
    .rs1_id_ex(rs1_id_ex), .rs2_id_ex(rs2_id_ex), .rd_id_ex(rd_id_ex),
    .mem_read_id_ex(mem_read_id_ex),
    .rd_ex_mem(rd_ex_mem), .rd_mem_wb(rd_mem_wb),
    .reg_write_ex_mem(reg_write_ex_mem), .reg_write_mem_wb(reg_write_mem_wb),
    .mc_start(mc_start), .branch_taken(branch_taken),
    .forward_rs1(f1_b), .forward_rs2(f2_b),
    .stall_pc(sp_b), .stall_if_id(sif_b), .stall_id_ex(sid_b),
    .bubble_id_ex(bub_b), .flush_if_id(fl_b), .mc_busy(busy_b),
    .stall_cycles(sc_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: remaining stall / flush cycles still owed, and the count.
  int     a_mc, a_fl, b_mc, b_fl;
  longint a_cnt, b_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (reg_write_ex_mem && rs == rd_ex_mem && rs != 0) return 2'b01;
    if (reg_write_mem_wb && rs == rd_mem_wb && rs != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic lu();
    return mem_read_id_ex && rd_id_ex != 0 && (rd_id_ex == rs1_if_id || rd_id_ex == rs2_if_id);
  endfunction

  task automatic model(input int ml, input int fc, input int cw,
                       input int mc, input int fl, input longint cnt,
                       output logic sp, output logic sid, output logic bub,
                       output logic fli, output logic busy,
                       output int mc_n, output int fl_n, output longint cnt_n);
    sp = 0; sid = 0; bub = 0; fli = 0; busy = 0;
    mc_n = mc; fl_n = fl;
    if (mc > 0) begin
      sp = 1; sid = 1; busy = 1; mc_n = mc - 1;
    end else if (fl > 0) begin
      bub = 1; fli = 1; fl_n = fl - 1;
    end else if (branch_taken) begin
      bub = 1; fli = 1; fl_n = fc - 1;
    end else if (mc_start) begin
      sp = 1; sid = 1; busy = 1; mc_n = ml - 1;
    end else if (lu()) begin
      sp = 1; bub = 1;
    end
    cnt_n = (sp && cnt < ((64'd1 << cw) - 1)) ? cnt + 1 : cnt;
  endtask

  // Caller sets inputs just after a falling edge; outputs are checked, the
  // clock rises, the reference advances and we return at the next falling edge.
  task automatic step();
    logic sp, sid, bub, fli, busy;
    int amn, afn, bmn, bfn;
    longint acn, bcn;
    #1;
    model(4, 2, 16, a_mc, a_fl, a_cnt, sp, sid, bub, fli, busy, amn, afn, acn);
    chk("a_stall_pc", sp_a, sp);
    chk("a_stall_if_id", sif_a, sp);
    chk("a_stall_id_ex", sid_a, sid);
    chk("a_bubble", bub_a, bub);
    chk("a_flush", fl_a, fli);
    chk("a_mc_busy", busy_a, busy);
    chk("a_stall_cycles", sc_a, a_cnt[31:0]);
    model(1, 1, 4, b_mc, b_fl, b_cnt, sp, sid, bub, fli, busy, bmn, bfn, bcn);
    chk("b_stall_pc", sp_b, sp);
    chk("b_stall_if_id", sif_b, sp);
    chk("b_stall_id_ex", sid_b, sid);
    chk("b_bubble", bub_b, bub);
    chk("b_flush", fl_b, fli);
    chk("b_mc_busy", busy_b, busy);
    chk("b_stall_cycles", sc_b, b_cnt[31:0]);
    chk("a_fwd1", f1_a, fwd(rs1_id_ex));
    chk("a_fwd2", f2_a, fwd(rs2_id_ex));
    chk("b_fwd1", f1_b, fwd(rs1_id_ex));
    chk("b_fwd2", f2_b, fwd(rs2_id_ex));
    @(posedge clk);
    a_mc = amn; a_fl = afn; a_cnt = acn;
    b_mc = bmn; b_fl = bfn; b_cnt = bcn;
    @(negedge clk);
  endtask

  task automatic idle_in();
    rs1_if_id = 0; rs2_if_id = 0; rs1_id_ex = 0; rs2_id_ex = 0;
    rd_id_ex = 0; rd_ex_mem = 0; rd_mem_wb = 0;
    mem_read_id_ex = 0; reg_write_ex_mem = 0; reg_write_mem_wb = 0;
    mc_start = 0; branch_taken = 0;
  endtask

  task automatic rand_in();
    rs1_if_id = AW'($urandom_range(0, 3)); rs2_if_id = AW'($urandom_range(0, 3));
    rs1_id_ex = AW'($urandom_range(0, 3)); rs2_id_ex = AW'($urandom_range(0, 3));
    rd_id_ex  = AW'($urandom_range(0, 3));
    rd_ex_mem = AW'($urandom_range(0, 3)); rd_mem_wb = AW'($urandom_range(0, 3));
    mem_read_id_ex   = 1'($urandom_range(0, 1));
    reg_write_ex_mem = 1'($urandom_range(0, 1));
    reg_write_mem_wb = 1'($urandom_range(0, 1));
    mc_start     = ($urandom_range(0, 9) == 0);
    branch_taken = ($urandom_range(0, 7) == 0);
  endtask

  // Asserted between edges so the clear is seen as asynchronous.
  task automatic do_reset();
    idle_in();
    rst_n = 0;
    #1;
    chk("rst_stall_a", {sp_a, sif_a, sid_a, busy_a}, 0);
    chk("rst_flush_a", {bub_a, fl_a}, 0);
    chk("rst_cnt_a", sc_a, 0);
    chk("rst_stall_b", {sp_b, sif_b, sid_b, busy_b, bub_b, fl_b}, 0);
    chk("rst_cnt_b", sc_b, 0);
    a_mc = 0; a_fl = 0; a_cnt = 0;
    b_mc = 0; b_fl = 0; b_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    do_reset();

    // Forwarding priority
    rs1_id_ex = 5; rd_ex_mem = 5; rd_mem_wb = 5;
    reg_write_ex_mem = 1; reg_write_mem_wb = 1; rs2_id_ex = 7;
    #1 chk("fwd_exmem_prio", f1_a, 2'b01);
    chk("fwd_rs2_none", f2_a, 2'b00);
    step();
    reg_write_ex_mem = 0;
    #1 chk("fwd_memwb", f1_a, 2'b10);
    step();
    reg_write_ex_mem = 1; rs1_id_ex = 0;
    #1 chk("fwd_x0", f1_a, 2'b00);
    step();

    // Load-use, then the same with rd = x0
    do_reset();
    mem_read_id_ex = 1; rd_id_ex = 3; rs2_if_id = 3;
    #1 chk("lu_stall", {sp_a, sif_a, bub_a, sid_a}, 4'b1110);
    step();
    rd_id_ex = 0;
    #1 chk("lu_x0_nostall", {sp_a, bub_a}, 0);
    step();
    chk("lu_count", sc_a, 1);

    // Multi-cycle op with an ignored branch in its shadow
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mc_start = (i == 0); branch_taken = (i == 2);
      #1 chk("mc_seq_stall", {sp_a, sif_a, sid_a, busy_a}, (i < 4) ? 4'hf : 4'h0);
      chk("mc_seq_noflush", fl_a, 0);
      step();
    end
    chk("mc_count", sc_a, 4);

    // Branch beats mc_start and load-use
    do_reset();
    for (int i = 0; i < 4; i++) begin
      branch_taken = (i == 0); mc_start = (i == 0);
      mem_read_id_ex = (i == 0); rd_id_ex = 3; rs2_if_id = 3;
      #1 chk("br_flush", {fl_a, bub_a}, (i < 2) ? 2'b11 : 2'b00);
      chk("br_flush_b", fl_b, i == 0);
      chk("br_nostall", {sp_a, busy_a}, 0);
      step();
    end

    // Reset in the middle of MC_WAIT
    do_reset();
    mc_start = 1; step();
    mc_start = 0; step();
    #1 chk("mid_mc_busy", busy_a, 1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1 chk("post_rst_idle", {sp_a, sif_a, sid_a, bub_a, fl_a, busy_a, f1_a, f2_a}, 0);
      step();
    end

    // Saturation of the narrow counter
    do_reset();
    mc_start = 1;
    for (int i = 0; i < 20; i++) step();
    mc_start = 0;
    step();
    chk("sat_b", sc_b, 15);
    chk("nosat_a", sc_a, 20);

    // Randomised run with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      rand_in();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
